// File: rtl/imm_gen_if.sv
// imm_gen_if: upstream/downstream handshake bus of the immediate generator stage.
interface imm_gen_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic            imm_err;

    modport master (
        output in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, imm, imm_err
    );

    modport slave (
        input  in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, imm, imm_err
    );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RV32I/RV64I immediate generator with a two-entry skid buffer.
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input logic      clk,
    input logic      rst_n,
    imm_gen_if.slave bus
);
    logic [31:0]     w;
    logic [XLEN-1:0] full;
    logic            new_err;
    logic            accept;
    logic            drain;
    logic            load;
    logic            out_valid;
    logic [XLEN-1:0] imm_q;
    logic            err_q;
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic            skid_err;
    logic            unused_opcode;

    assign w             = bus.instr;
    assign unused_opcode = ^w[6:0];
    assign new_err       = bus.imm_src == 3'b111;
    assign accept        = bus.in_valid & ~skid_valid;
    assign drain         = out_valid & bus.out_ready;
    assign load          = ~out_valid | drain;

    // Built at 64 bits and truncated, so XLEN=32 simply drops the upper half.
    always_comb begin
        full = '0;
        case (bus.imm_src)
            3'b000:  full = XLEN'({{52{w[31]}}, w[31:20]});
            3'b001:  full = XLEN'({{52{w[31]}}, w[31:25], w[11:7]});
            3'b010:  full = XLEN'({{52{w[31]}}, w[7], w[30:25], w[11:8], 1'b0});
            3'b011:  full = XLEN'({{32{w[31]}}, w[31:12], 12'b0});
            3'b100:  full = XLEN'({{44{w[31]}}, w[19:12], w[20], w[30:21], 1'b0});
            3'b101:  full = (XLEN == 64) ? XLEN'({58'b0, w[25:20]}) : XLEN'({59'b0, w[24:20]});
            3'b110:  full = XLEN'({59'b0, w[19:15]});
            default: full = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            imm_q      <= '0;
            err_q      <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_err   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= skid_valid | accept;
                if (skid_valid | accept) begin
                    imm_q <= skid_valid ? skid_imm : full;
                    err_q <= skid_valid ? skid_err : new_err;
                end
            end
            if (load & skid_valid) begin
                skid_valid <= 1'b0;
            end else if (accept & ~load) begin
                skid_valid <= 1'b1;
                skid_imm   <= full;
                skid_err   <= new_err;
            end
        end
    end

    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = out_valid;
    assign bus.imm       = imm_q;
    assign bus.imm_err   = err_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed and randomised checks of imm_gen_stage at XLEN=32 and XLEN=64 side by side.
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  imm_src = '0;
    int          vectors = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
    } exp_t;

    imm_gen_if #(.XLEN(32)) b32 ();
    imm_gen_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.instr     = instr;
    assign b32.imm_src   = imm_src;
    assign b32.out_ready = out_ready;
    assign b64.in_valid  = in_valid;
    assign b64.instr     = instr;
    assign b64.imm_src   = imm_src;
    assign b64.out_ready = out_ready;

    imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t ref_imm(input logic [31:0] x, input logic [2:0] src);
        exp_t r;
        logic [63:0] v;
        case (src)
            3'd0:    v = 64'($signed(x[31:20]));
            3'd1:    v = 64'($signed({x[31:25], x[11:7]}));
            3'd2:    v = 64'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
            3'd3:    v = 64'($signed({x[31:12], 12'h000}));
            3'd4:    v = 64'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
            3'd5:    v = {58'h0, x[25:20]};
            3'd6:    v = {59'h0, x[19:15]};
            default: v = '0;
        endcase
        r.e64 = v;
        r.e32 = (src == 3'd5) ? {27'h0, x[24:20]} : v[31:0];
        r.err = src == 3'd7;
        return r;
    endfunction

    task automatic test_reset;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) step();
        vectors++;
        if ({b32.out_valid, b32.in_ready, b32.imm, b32.imm_err} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset32: got ov=%b ir=%b imm=%h err=%b, want 0 1 0 0", b32.out_valid, b32.in_ready, b32.imm, b32.imm_err);
        end
        vectors++;
        if ({b64.out_valid, b64.in_ready, b64.imm, b64.imm_err} !== {1'b0, 1'b1, 64'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset64: got ov=%b ir=%b imm=%h err=%b, want 0 1 0 0", b64.out_valid, b64.in_ready, b64.imm, b64.imm_err);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back;
        logic [31:0] w[5] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7, 32'h0010006F};
        logic [63:0] e[5] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'h12345000, 64'h800};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            instr = w[k];
            imm_src = 3'(k);
            in_valid = 1'b1;
            step();
            vectors++;
            if ({b32.out_valid, b32.imm, b32.imm_err} !== {1'b1, e[k][31:0], 1'b0}) begin
                errors++;
                $display("FAIL b2b32[%0d]: got ov=%b imm=%h err=%b, want 1 %h 0", k, b32.out_valid, b32.imm, b32.imm_err, e[k][31:0]);
            end
            vectors++;
            if ({b64.out_valid, b64.imm, b64.imm_err} !== {1'b1, e[k], 1'b0}) begin
                errors++;
                $display("FAIL b2b64[%0d]: got ov=%b imm=%h err=%b, want 1 %h 0", k, b64.out_valid, b64.imm, b64.imm_err, e[k]);
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: got ov32=%b ov64=%b, want 0 0", b32.out_valid, b64.out_valid);
        end
    endtask

    task automatic test_formats;
        logic [31:0] w[6]  = '{32'h800000B7, 32'h03F0D093, 32'h000FD073, 32'hFFFFFFFF, 32'h12345678, 32'h7FF00093};
        logic [2:0]  s[6]  = '{3'd3, 3'd5, 3'd6, 3'd7, 3'd7, 3'd0};
        logic [31:0] e3[6] = '{32'h80000000, 32'h1F, 32'h1F, 32'h0, 32'h0, 32'h7FF};
        logic [63:0] e6[6] = '{64'hFFFFFFFF80000000, 64'h3F, 64'h1F, 64'h0, 64'h0, 64'h7FF};
        logic        er[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            instr = w[k];
            imm_src = s[k];
            in_valid = 1'b1;
            step();
            vectors++;
            if ({b32.out_valid, b32.imm, b32.imm_err} !== {1'b1, e3[k], er[k]}) begin
                errors++;
                $display("FAIL fmt32[%0d]: got ov=%b imm=%h err=%b, want 1 %h %b", k, b32.out_valid, b32.imm, b32.imm_err, e3[k], er[k]);
            end
            vectors++;
            if ({b64.out_valid, b64.imm, b64.imm_err} !== {1'b1, e6[k], er[k]}) begin
                errors++;
                $display("FAIL fmt64[%0d]: got ov=%b imm=%h err=%b, want 1 %h %b", k, b64.out_valid, b64.imm, b64.imm_err, e6[k], er[k]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall;
        logic [31:0] w[4] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
        int nxt = 2;
        logic acc;
        out_ready = 1'b0;
        imm_src = 3'd0;
        in_valid = 1'b1;
        instr = w[0];
        step();
        vectors++;
        if ({b32.in_ready, b32.out_valid, b32.imm} !== {1'b1, 1'b1, 32'h1}) begin
            errors++;
            $display("FAIL stall_first: got ir=%b ov=%b imm=%h, want 1 1 1", b32.in_ready, b32.out_valid, b32.imm);
        end
        instr = w[1];
        step();
        vectors++;
        if ({b32.in_ready, b32.out_valid, b32.imm, b64.in_ready} !== {1'b0, 1'b1, 32'h1, 1'b0}) begin
            errors++;
            $display("FAIL stall_skid: got ir=%b ov=%b imm=%h ir64=%b, want 0 1 1 0", b32.in_ready, b32.out_valid, b32.imm, b64.in_ready);
        end
        instr = w[2];
        repeat (3) step();
        vectors++;
        if ({b32.in_ready, b32.out_valid, b32.imm, b64.imm} !== {1'b0, 1'b1, 32'h1, 64'h1}) begin
            errors++;
            $display("FAIL stall_hold: got ir=%b ov=%b imm32=%h imm64=%h, want 0 1 1 1", b32.in_ready, b32.out_valid, b32.imm, b64.imm);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({b32.out_valid, b32.imm, b64.imm} !== {1'b1, 32'(k + 1), 64'(k + 1)}) begin
                errors++;
                $display("FAIL stall_order[%0d]: got ov=%b imm32=%h imm64=%h, want 1 %0d", k, b32.out_valid, b32.imm, b64.imm, k + 1);
            end
            acc = in_valid && b32.in_ready;
            step();
            if (acc) begin
                nxt++;
                if (nxt < 4) instr = w[nxt];
                else in_valid = 1'b0;
            end
            if (k == 0) begin
                vectors++;
                if (b32.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_ready_rise: got ir=%b, want 1", b32.in_ready);
                end
            end
        end
        vectors++;
        if (b32.out_valid !== 1'b0 || in_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drained: got ov=%b in_valid=%b, want 0 0", b32.out_valid, in_valid);
        end
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t f;
        int sent = 0;
        int got = 0;
        logic acc, dr, prev_stall;
        prev_stall = 1'b0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            if (!in_valid && sent < 10000 && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                instr = $urandom;
                imm_src = 3'($urandom_range(7));
            end
            out_ready = $urandom_range(3) != 0;
            vectors++;
            if (b32.out_valid !== (q.size() != 0) || b32.in_ready !== (q.size() < 2) ||
                b64.out_valid !== (q.size() != 0) || b64.in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rand_occupancy: got ov=%b/%b ir=%b/%b with %0d queued", b32.out_valid, b64.out_valid, b32.in_ready, b64.in_ready, q.size());
            end
            if (prev_stall) begin
                vectors++;
                if (b32.out_valid !== 1'b1 || b64.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_valid_drop: got ov=%b/%b, want 1", b32.out_valid, b64.out_valid);
                end
            end
            acc = in_valid && b32.in_ready;
            dr = b32.out_valid && out_ready;
            if (dr) begin
                vectors++;
                got++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: output imm=%h with nothing outstanding", b32.imm);
                end else begin
                    f = q.pop_front();
                    if (b32.imm !== f.e32 || b64.imm !== f.e64 || b32.imm_err !== f.err || b64.imm_err !== f.err) begin
                        errors++;
                        $display("FAIL rand_data[%0d]: got %h/%h err %b/%b, want %h/%h err %b", got, b32.imm, b64.imm, b32.imm_err, b64.imm_err, f.e32, f.e64, f.err);
                    end
                end
            end
            if (acc) begin
                q.push_back(ref_imm(instr, imm_src));
                sent++;
            end
            prev_stall = b32.out_valid && !out_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        vectors++;
        if (got != 10000 || sent != 10000 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: got sent=%0d received=%0d left=%0d, want 10000 10000 0", sent, got, q.size());
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        imm_src = 3'd0;
        in_valid = 1'b1;
        instr = 32'h00500093;
        step();
        instr = 32'h00600093;
        step();
        in_valid = 1'b0;
        vectors++;
        if ({b32.out_valid, b32.in_ready, b64.out_valid, b64.in_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL rmid_full: got ov=%b ir=%b ov64=%b ir64=%b, want 1 0 1 0", b32.out_valid, b32.in_ready, b64.out_valid, b64.in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({b32.out_valid, b32.in_ready, b32.imm, b64.out_valid, b64.in_ready, b64.imm} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 64'h0}) begin
            errors++;
            $display("FAIL rmid_async: got ov=%b ir=%b imm=%h ov64=%b ir64=%b imm64=%h, want 0 1 0", b32.out_valid, b32.in_ready, b32.imm, b64.out_valid, b64.in_ready, b64.imm);
        end
        @(negedge clk) rst_n = 1'b1;
        instr = 32'h00700093;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if ({b32.out_valid, b32.imm, b64.out_valid, b64.imm} !== {1'b1, 32'h7, 1'b1, 64'h7}) begin
            errors++;
            $display("FAIL rmid_restart: got ov=%b imm=%h ov64=%b imm64=%h, want 1 7 1 7", b32.out_valid, b32.imm, b64.out_valid, b64.imm);
        end
        step();
        vectors++;
        if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_single: got ov=%b ov64=%b, want 0 0", b32.out_valid, b64.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_formats();
        test_stall();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
